// File: rtl/vga_pkg.sv
// Shared raster timing types, the 640x480 reference timing and total helpers.
package vga_pkg;

  localparam int unsigned AXIS_W = 16;

  typedef struct packed {
    logic [AXIS_W-1:0] active;
    logic [AXIS_W-1:0] fp;
    logic [AXIS_W-1:0] sync;
    logic [AXIS_W-1:0] bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480 = '{
    h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
    v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd29}
  };

  localparam int unsigned VGA_640x480_CLK_DIV = 2;

  function automatic int unsigned axis_total(input vga_axis_t a);
    return 32'(a.active) + 32'(a.fp) + 32'(a.sync) + 32'(a.bp);
  endfunction

  function automatic int unsigned h_total(input vga_timing_t t);
    return axis_total(t.h);
  endfunction

  function automatic int unsigned v_total(input vga_timing_t t);
    return axis_total(t.v);
  endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the increment that returns to 0.
module wrap_counter #(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic         at_max_c;

  assign at_max_c = (q_q == W'(MAX));

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = at_max_c ? '0 : q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign wrap = inc & at_max_c;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel divider, column and row counters chained
// by wrap, plus a completed-frame counter; all timing outputs decode directly from state.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 32'(VGA_640x480.h.active),
  parameter int unsigned H_FP     = 32'(VGA_640x480.h.fp),
  parameter int unsigned H_SYNC   = 32'(VGA_640x480.h.sync),
  parameter int unsigned H_BP     = 32'(VGA_640x480.h.bp),
  parameter int unsigned V_ACTIVE = 32'(VGA_640x480.v.active),
  parameter int unsigned V_FP     = 32'(VGA_640x480.v.fp),
  parameter int unsigned V_SYNC   = 32'(VGA_640x480.v.sync),
  parameter int unsigned V_BP     = 32'(VGA_640x480.v.bp),
  parameter int unsigned CLK_DIV  = VGA_640x480_CLK_DIV,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PREFETCH = 5,
  parameter int unsigned FRAME_W  = 16,
  localparam vga_timing_t TIMING = '{
    h: '{active: AXIS_W'(H_ACTIVE), fp: AXIS_W'(H_FP), sync: AXIS_W'(H_SYNC), bp: AXIS_W'(H_BP)},
    v: '{active: AXIS_W'(V_ACTIVE), fp: AXIS_W'(V_FP), sync: AXIS_W'(V_SYNC), bp: AXIS_W'(V_BP)}
  },
  localparam int unsigned H_TOTAL = h_total(TIMING),
  localparam int unsigned V_TOTAL = v_total(TIMING),
  localparam int unsigned COL_W   = $clog2(H_TOTAL),
  localparam int unsigned ROW_W   = $clog2(V_TOTAL)
) (
  input  logic               CLOCK_50,
  input  logic               reset_L,
  input  logic               en,
  input  logic               restart,
  output logic               HS,
  output logic               VS,
  output logic               h_blank,
  output logic               v_blank,
  output logic               blank,
  output logic               pix_en,
  output logic               line_start,
  output logic               frame_start,
  output logic               prefetch,
  output logic [COL_W-1:0]   col,
  output logic [ROW_W-1:0]   row,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HS_START  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END    = HS_START + H_SYNC;
  localparam int unsigned VS_START  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END    = VS_START + V_SYNC;
  localparam int unsigned LINE_CLKS = H_TOTAL * CLK_DIV;
  localparam int unsigned PF_START  = LINE_CLKS - PREFETCH;

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_interval
    $error("vga_timing_gen: every timing interval must be non-zero");
  end
  if (PREFETCH < 1 || PREFETCH > LINE_CLKS) begin : g_bad_prefetch
    $error("vga_timing_gen: PREFETCH must lie in 1..H_TOTAL*CLK_DIV");
  end

  logic [DIV_W-1:0]   div_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;
  logic               adv_c;
  logic               div_wrap_c;
  logic               col_wrap_c;
  logic               row_wrap_c;
  logic [31:0]        line_pos_c;

  // restart wins over en, so a restart on the last frame clock never counts a frame
  assign adv_c = en & ~restart;

  wrap_counter #(.MAX(CLK_DIV - 1), .W(DIV_W)) u_div (
    .clk     (CLOCK_50),
    .reset_L (reset_L),
    .inc     (adv_c),
    .clr     (restart),
    .q       (div_q),
    .wrap    (div_wrap_c)
  );

  wrap_counter #(.MAX(H_TOTAL - 1), .W(COL_W)) u_col (
    .clk     (CLOCK_50),
    .reset_L (reset_L),
    .inc     (div_wrap_c),
    .clr     (restart),
    .q       (col_q),
    .wrap    (col_wrap_c)
  );

  wrap_counter #(.MAX(V_TOTAL - 1), .W(ROW_W)) u_row (
    .clk     (CLOCK_50),
    .reset_L (reset_L),
    .inc     (col_wrap_c),
    .clr     (restart),
    .q       (row_q),
    .wrap    (row_wrap_c)
  );

  always_comb begin
    frame_d = frame_q;
    if (row_wrap_c) begin
      frame_d = frame_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_L) begin
    if (!reset_L) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  // Clock offset within the line, used for the prefetch window
  assign line_pos_c = 32'(col_q) * CLK_DIV + 32'(div_q);

  assign HS          = ((32'(col_q) >= HS_START) && (32'(col_q) < HS_END)) ? HS_POL : ~HS_POL;
  assign VS          = ((32'(row_q) >= VS_START) && (32'(row_q) < VS_END)) ? VS_POL : ~VS_POL;
  assign h_blank     = (32'(col_q) >= H_ACTIVE);
  assign v_blank     = (32'(row_q) >= V_ACTIVE);
  assign blank       = h_blank | v_blank;
  assign pix_en      = (div_q == DIV_W'(CLK_DIV - 1));
  assign line_start  = en & (col_q == '0) & (div_q == '0);
  assign frame_start = line_start & (row_q == '0);
  assign prefetch    = (line_pos_c >= PF_START);
  assign col         = col_q;
  assign row         = row_q;
  assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, tiny, medium) checked every
// cycle against a frame-position model, plus hand-computed literal pins.
module tb_vga_timing_gen;

  localparam int unsigned HA   [3] = '{640, 4, 8};
  localparam int unsigned HF   [3] = '{16, 1, 2};
  localparam int unsigned HSY  [3] = '{96, 1, 3};
  localparam int unsigned HB   [3] = '{48, 1, 2};
  localparam int unsigned VA   [3] = '{480, 2, 4};
  localparam int unsigned VF   [3] = '{10, 1, 1};
  localparam int unsigned VSY  [3] = '{2, 1, 2};
  localparam int unsigned VB   [3] = '{29, 1, 1};
  localparam int unsigned HT   [3] = '{800, 7, 15};
  localparam int unsigned VT   [3] = '{521, 5, 8};
  localparam int unsigned DV   [3] = '{2, 1, 3};
  localparam bit          HPOL [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit          VPOL [3] = '{1'b0, 1'b1, 1'b1};
  localparam int unsigned PF   [3] = '{5, 2, 4};
  localparam int unsigned FW   [3] = '{16, 4, 8};

  logic clk;
  logic [2:0] rst_v, en_v, rs_v;
  logic [2:0] hs_w, vs_w, hb_w, vb_w, bl_w, pe_w, ls_w, fs_w, pf_w;
  logic [9:0]  col0, row0;
  logic [15:0] fc0;
  logic [2:0]  col1, row1;
  logic [3:0]  fc1;
  logic [3:0]  col2;
  logic [2:0]  row2;
  logic [7:0]  fc2;

  logic [63:0] act_v [3];
  int unsigned col_a [3];
  int unsigned row_a [3];
  int unsigned fc_a  [3];
  int unsigned pos [3] = '{0, 0, 0};
  int unsigned frm [3] = '{0, 0, 0};
  int n_tests = 0;
  int n_fail  = 0;

  vga_timing_gen u_dut0 (
    .CLOCK_50(clk), .reset_L(rst_v[0]), .en(en_v[0]), .restart(rs_v[0]),
    .HS(hs_w[0]), .VS(vs_w[0]), .h_blank(hb_w[0]), .v_blank(vb_w[0]), .blank(bl_w[0]),
    .pix_en(pe_w[0]), .line_start(ls_w[0]), .frame_start(fs_w[0]), .prefetch(pf_w[0]),
    .col(col0), .row(row0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HSY[1]), .H_BP(HB[1]),
    .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VSY[1]), .V_BP(VB[1]),
    .CLK_DIV(DV[1]), .HS_POL(HPOL[1]), .VS_POL(VPOL[1]), .PREFETCH(PF[1]), .FRAME_W(FW[1])
  ) u_dut1 (
    .CLOCK_50(clk), .reset_L(rst_v[1]), .en(en_v[1]), .restart(rs_v[1]),
    .HS(hs_w[1]), .VS(vs_w[1]), .h_blank(hb_w[1]), .v_blank(vb_w[1]), .blank(bl_w[1]),
    .pix_en(pe_w[1]), .line_start(ls_w[1]), .frame_start(fs_w[1]), .prefetch(pf_w[1]),
    .col(col1), .row(row1), .frame_cnt(fc1)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HSY[2]), .H_BP(HB[2]),
    .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VSY[2]), .V_BP(VB[2]),
    .CLK_DIV(DV[2]), .HS_POL(HPOL[2]), .VS_POL(VPOL[2]), .PREFETCH(PF[2]), .FRAME_W(FW[2])
  ) u_dut2 (
    .CLOCK_50(clk), .reset_L(rst_v[2]), .en(en_v[2]), .restart(rs_v[2]),
    .HS(hs_w[2]), .VS(vs_w[2]), .h_blank(hb_w[2]), .v_blank(vb_w[2]), .blank(bl_w[2]),
    .pix_en(pe_w[2]), .line_start(ls_w[2]), .frame_start(fs_w[2]), .prefetch(pf_w[2]),
    .col(col2), .row(row2), .frame_cnt(fc2)
  );

  assign act_v[0] = {hs_w[0], vs_w[0], hb_w[0], vb_w[0], bl_w[0], pe_w[0], ls_w[0], fs_w[0],
                     pf_w[0], 7'd0, 16'(col0), 16'(row0), 16'(fc0)};
  assign act_v[1] = {hs_w[1], vs_w[1], hb_w[1], vb_w[1], bl_w[1], pe_w[1], ls_w[1], fs_w[1],
                     pf_w[1], 7'd0, 16'(col1), 16'(row1), 16'(fc1)};
  assign act_v[2] = {hs_w[2], vs_w[2], hb_w[2], vb_w[2], bl_w[2], pe_w[2], ls_w[2], fs_w[2],
                     pf_w[2], 7'd0, 16'(col2), 16'(row2), 16'(fc2)};
  assign col_a[0] = 32'(col0);
  assign col_a[1] = 32'(col1);
  assign col_a[2] = 32'(col2);
  assign row_a[0] = 32'(row0);
  assign row_a[1] = 32'(row1);
  assign row_a[2] = 32'(row2);
  assign fc_a[0]  = 32'(fc0);
  assign fc_a[1]  = 32'(fc1);
  assign fc_a[2]  = 32'(fc2);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: each instance is just an absolute clock position inside the frame plus a frame tally
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_v[d]) begin
        pos[d] <= 0;
        frm[d] <= 0;
      end else if (rs_v[d]) begin
        pos[d] <= 0;
      end else if (en_v[d]) begin
        if (pos[d] == HT[d] * DV[d] * VT[d] - 1) begin
          pos[d] <= 0;
          frm[d] <= frm[d] + 1;
        end else begin
          pos[d] <= pos[d] + 1;
        end
      end
    end
  end

  function automatic logic [63:0] model_vec(input int d, input logic e, input int unsigned p,
                                            input int unsigned f);
    int unsigned lc, off, c, dv, r;
    logic hs, vs, hb, vb, pe, ls, fs, pf;
    lc  = HT[d] * DV[d];
    off = p % lc;
    c   = off / DV[d];
    dv  = off % DV[d];
    r   = p / lc;
    hs  = (c >= HA[d] + HF[d] && c < HA[d] + HF[d] + HSY[d]) ? HPOL[d] : ~HPOL[d];
    vs  = (r >= VA[d] + VF[d] && r < VA[d] + VF[d] + VSY[d]) ? VPOL[d] : ~VPOL[d];
    hb  = (c >= HA[d]);
    vb  = (r >= VA[d]);
    pe  = (dv == DV[d] - 1);
    ls  = e && (off == 0);
    fs  = ls && (r == 0);
    pf  = (off >= lc - PF[d]);
    return {hs, vs, hb, vb, hb | vb, pe, ls, fs, pf, 7'd0, 16'(c), 16'(r),
            16'(f % (32'(1) << FW[d]))};
  endfunction

  task automatic compare_all();
    logic [63:0] e;
    for (int d = 0; d < 3; d++) begin
      e = rst_v[d] ? model_vec(d, en_v[d], pos[d], frm[d]) : model_vec(d, en_v[d], 0, 0);
      n_tests++;
      if (act_v[d] !== e) begin
        n_fail++;
        $display("FAIL cycle dut%0d t=%0t got=%h want=%h (hs,vs,hb,vb,bl,pe,ls,fs,pf|col|row|frame)",
                 d, $time, act_v[d], e);
      end
    end
  endtask

  // Compare at the falling edge, then return 1 time unit after the next rising edge
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_at(input int d, input int unsigned r, input int unsigned c, input bit last,
                         input int limit, input string nm);
    int k;
    k = 0;
    while (!(row_a[d] == r && col_a[d] == c && (!last || pe_w[d])) && k < limit) begin
      tick();
      k++;
    end
    n_tests++;
    if (k >= limit) begin
      n_fail++;
      $display("FAIL %s: position not reached in %0d clocks, want row %0d col %0d", nm, limit, r, c);
    end
  endtask

  initial begin
    int hs_first, hs_cnt, pf_first, pf_cnt, ls_cnt, pe_cnt;
    int fs1_cnt, hs1_cnt, pf1_cnt, vs2_cnt;
    rst_v = 3'b000;
    en_v  = 3'b000;
    rs_v  = 3'b000;
    #2;
    chk("reset_hs0", 32'(hs_w[0]), 1);
    chk("reset_hs1", 32'(hs_w[1]), 0);
    chk("reset_pix_en0", 32'(pe_w[0]), 0);
    chk("reset_pix_en1", 32'(pe_w[1]), 1);
    repeat (3) tick();

    rst_v = 3'b111;
    en_v  = 3'b111;
    #1;
    chk("first_frame_start0", 32'(fs_w[0]), 1);

    // One full default line: HS / prefetch windows and strobes by clock offset
    hs_first = -1; hs_cnt = 0; pf_first = -1; pf_cnt = 0; ls_cnt = 0; pe_cnt = 0;
    fs1_cnt = 0; hs1_cnt = 0; pf1_cnt = 0; vs2_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      if (hs_w[0] == 1'b0) begin
        if (hs_first < 0) hs_first = i;
        hs_cnt++;
      end
      if (pf_w[0]) begin
        if (pf_first < 0) pf_first = i;
        pf_cnt++;
      end
      if (ls_w[0]) ls_cnt++;
      if (pe_w[0]) pe_cnt++;
      if (fs_w[1]) fs1_cnt++;
      if (hs_w[1]) hs1_cnt++;
      if (pf_w[1]) pf1_cnt++;
      if (vs_w[2]) vs2_cnt++;
      tick();
    end
    chk("hs_low_first_offset", 32'(hs_first), 1312);
    chk("hs_low_clocks", 32'(hs_cnt), 192);
    chk("prefetch_first_offset", 32'(pf_first), 1595);
    chk("prefetch_clocks", 32'(pf_cnt), 5);
    chk("line_start_per_line", 32'(ls_cnt), 1);
    chk("pix_en_per_line", 32'(pe_cnt), 800);
    chk("line_period_ls", 32'(ls_w[0]), 1);
    chk("line_period_row", row_a[0], 1);
    chk("small_frame_starts", 32'(fs1_cnt), 46);
    chk("small_hs_high_clocks", 32'(hs1_cnt), 228);
    chk("small_prefetch_clocks", 32'(pf1_cnt), 456);
    chk("small_frame_cnt_wrapped", fc_a[1], 13);
    chk("med_vs_high_clocks", 32'(vs2_cnt), 360);
    chk("med_frame_cnt", fc_a[2], 4);

    // Hold at row 5 col 300
    wait_at(0, 5, 300, 1'b0, 20000, "reach_hold_point");
    en_v[0] = 1'b0;
    repeat (50) tick();
    chk("hold_row", row_a[0], 5);
    chk("hold_col", col_a[0], 300);
    chk("hold_pix_en", 32'(pe_w[0]), 0);
    chk("hold_line_start", 32'(ls_w[0]), 0);
    en_v[0] = 1'b1;
    tick();
    chk("resume_col", col_a[0], 300);
    chk("resume_pix_en", 32'(pe_w[0]), 1);
    tick();
    chk("resume_next_col", col_a[0], 301);

    // Restart while held, then while running
    en_v[0] = 1'b0;
    rs_v[0] = 1'b1;
    tick();
    rs_v[0] = 1'b0;
    chk("restart_hold_row", row_a[0], 0);
    chk("restart_hold_col", col_a[0], 0);
    chk("restart_hold_fs", 32'(fs_w[0]), 0);
    chk("restart_hold_frame", fc_a[0], 0);
    en_v[0] = 1'b1;
    #1;
    chk("restart_hold_fs_en", 32'(fs_w[0]), 1);
    repeat (10) tick();
    rs_v[0] = 1'b1;
    tick();
    rs_v[0] = 1'b0;
    chk("restart_run_col", col_a[0], 0);
    chk("restart_run_fs", 32'(fs_w[0]), 1);

    // Restart on the final clock of a frame must not count the frame
    rst_v[2] = 1'b0;
    tick();
    tick();
    rst_v[2] = 1'b1;
    wait_at(2, 7, 14, 1'b1, 1000, "reach_last_clock_a");
    rs_v[2] = 1'b1;
    tick();
    rs_v[2] = 1'b0;
    chk("restart_last_frame_cnt", fc_a[2], 0);
    chk("restart_last_row", row_a[2], 0);
    chk("restart_last_col", col_a[2], 0);
    wait_at(2, 7, 14, 1'b1, 1000, "reach_last_clock_b");
    tick();
    chk("frame_wrap_cnt", fc_a[2], 1);
    chk("frame_wrap_row", row_a[2], 0);
    chk("frame_wrap_fs", 32'(fs_w[2]), 1);

    // Asynchronous reset in the middle of an HS pulse
    wait_at(0, 3, 700, 1'b0, 10000, "reach_reset_point");
    chk("pre_reset_hs", 32'(hs_w[0]), 0);
    rst_v[0] = 1'b0;
    en_v[0]  = 1'b0;
    #1;
    chk("async_reset_hs", 32'(hs_w[0]), 1);
    chk("async_reset_vs", 32'(vs_w[0]), 1);
    chk("async_reset_row", row_a[0], 0);
    chk("async_reset_col", col_a[0], 0);
    repeat (3) tick();
    rst_v[0] = 1'b1;
    repeat (2) tick();
    chk("post_reset_fs_held", 32'(fs_w[0]), 0);
    en_v[0] = 1'b1;
    #1;
    chk("post_reset_fs_en", 32'(fs_w[0]), 1);
    repeat (100) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
